// File: rtl/vx_ibuffer_sched_if.sv
// Decode/issue-side bundle of the instruction buffer.
//   slave  : the buffer (takes enq, stall and flush; produces deq and occupancy)
//   master : the surrounding pipeline (decode + issue/scoreboard)
// warp_used packs per-warp occupancy, warp i at [i*CW +: CW].
interface vx_ibuffer_sched_if #(
    parameter int NUM_WARPS = 4,
    parameter int DEPTH     = 2,
    parameter int DATAW     = 64
);
    localparam int WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic                    enq_valid;
    logic [WW-1:0]           enq_wid;
    logic [DATAW-1:0]        enq_data;
    logic                    enq_ready;
    logic                    deq_valid;
    logic [WW-1:0]           deq_wid;
    logic [DATAW-1:0]        deq_data;
    logic                    deq_ready;
    logic [NUM_WARPS-1:0]    stall_mask;
    logic                    flush_valid;
    logic [WW-1:0]           flush_wid;
    logic [NUM_WARPS*CW-1:0] warp_used;

    modport master (
        output enq_valid, enq_wid, enq_data, deq_ready, stall_mask, flush_valid, flush_wid,
        input  enq_ready, deq_valid, deq_wid, deq_data, warp_used
    );
    modport slave (
        input  enq_valid, enq_wid, enq_data, deq_ready, stall_mask, flush_valid, flush_wid,
        output enq_ready, deq_valid, deq_wid, deq_data, warp_used
    );
endinterface

// File: rtl/vx_ibuffer_sched.sv
// Per-warp instruction buffer with a scheduled, held-until-accepted issue register.
// One FIFO per warp (DEPTH entries each) feeds a single output register chosen by
// round-robin (SCHED_MODE=0) or greedy (SCHED_MODE=1) selection.
// Ports:
//   clk   - clock
//   reset - asynchronous, active-low reset
//   bus   - slave side of vx_ibuffer_sched_if (enq, deq, stall_mask, flush, warp_used)
module vx_ibuffer_sched #(
    parameter int NUM_WARPS  = 4,
    parameter int DEPTH      = 2,
    parameter int DATAW      = 64,
    parameter int SCHED_MODE = 0
) (
    input logic               clk,
    input logic               reset,
    vx_ibuffer_sched_if.slave bus
);
    localparam int WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATAW-1:0] mem_q [NUM_WARPS][DEPTH];
    logic [DATAW-1:0] mem_d [NUM_WARPS][DEPTH];
    logic [PW-1:0]    rd_ptr_q [NUM_WARPS], rd_ptr_d [NUM_WARPS];
    logic [PW-1:0]    wr_ptr_q [NUM_WARPS], wr_ptr_d [NUM_WARPS];
    logic [CW-1:0]    used_q [NUM_WARPS], used_d [NUM_WARPS];
    logic             deq_valid_q, deq_valid_d;
    logic [WW-1:0]    deq_wid_q, deq_wid_d;
    logic [DATAW-1:0] deq_data_q, deq_data_d;
    logic [WW-1:0]    last_grant_q, last_grant_d;

    logic                 enq_ready, enq_fire, reload, grant, rr_found;
    logic [NUM_WARPS-1:0] elig;
    logic [WW-1:0]        rr_wid, win;

    // Wrap modulo DEPTH so non-power-of-2 depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Full or being flushed: refuse, even if the same warp is popped this cycle.
    assign enq_ready = (used_q[bus.enq_wid] != CW'(DEPTH)) &&
                       !(bus.flush_valid && bus.flush_wid == bus.enq_wid);
    assign enq_fire  = bus.enq_valid && enq_ready;

    // A held instruction of the flushed warp is dropped, so the register refills.
    assign reload = !deq_valid_q || bus.deq_ready ||
                    (bus.flush_valid && bus.flush_wid == deq_wid_q);

    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            elig[w] = (used_q[w] != '0 || (enq_fire && bus.enq_wid == WW'(w))) &&
                      !bus.stall_mask[w] &&
                      !(bus.flush_valid && bus.flush_wid == WW'(w));
        end
    end

    // Round-robin scan starting just after the last grant.
    always_comb begin
        int idx;
        idx      = 0;
        rr_found = 1'b0;
        rr_wid   = '0;
        for (int i = 1; i <= NUM_WARPS; i++) begin
            idx = (int'(last_grant_q) + i) % NUM_WARPS;
            if (!rr_found && elig[idx]) begin
                rr_found = 1'b1;
                rr_wid   = WW'(idx);
            end
        end
    end

    always_comb begin
        if (SCHED_MODE == 1 && elig[last_grant_q]) begin
            win = last_grant_q;
        end else begin
            win = rr_wid;
        end
        grant = reload && (rr_found || (SCHED_MODE == 1 && elig[last_grant_q]));
    end

    always_comb begin
        logic push, pop, bypass;
        mem_d        = mem_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        used_d       = used_q;
        deq_valid_d  = deq_valid_q;
        deq_wid_d    = deq_wid_q;
        deq_data_d   = deq_data_q;
        last_grant_d = last_grant_q;
        push         = 1'b0;
        pop          = 1'b0;
        bypass       = 1'b0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            // An empty winner can only be eligible through this cycle's enq,
            // which then goes straight to the output register instead.
            bypass = grant && win == WW'(w) && used_q[w] == '0;
            push   = enq_fire && bus.enq_wid == WW'(w) && !bypass;
            pop    = grant && win == WW'(w) && used_q[w] != '0;
            if (push) begin
                mem_d[w][wr_ptr_q[w]] = bus.enq_data;
                wr_ptr_d[w]           = ptr_inc(wr_ptr_q[w]);
            end
            if (pop) rd_ptr_d[w] = ptr_inc(rd_ptr_q[w]);
            used_d[w] = used_q[w] + CW'(push) - CW'(pop);
            if (bus.flush_valid && bus.flush_wid == WW'(w)) begin
                used_d[w]   = '0;
                rd_ptr_d[w] = '0;
                wr_ptr_d[w] = '0;
            end
        end
        if (reload) begin
            deq_valid_d = grant;
            if (grant) begin
                deq_wid_d    = win;
                last_grant_d = win;
                deq_data_d   = (used_q[win] != '0) ? mem_q[win][rd_ptr_q[win]] : bus.enq_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                rd_ptr_q[w] <= '0;
                wr_ptr_q[w] <= '0;
                used_q[w]   <= '0;
            end
            deq_valid_q  <= 1'b0;
            deq_wid_q    <= '0;
            deq_data_q   <= '0;
            last_grant_q <= WW'(NUM_WARPS - 1);
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            used_q       <= used_d;
            deq_valid_q  <= deq_valid_d;
            deq_wid_q    <= deq_wid_d;
            deq_data_q   <= deq_data_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.enq_ready = enq_ready;
    assign bus.deq_valid = deq_valid_q;
    assign bus.deq_wid   = deq_wid_q;
    assign bus.deq_data  = deq_data_q;

    for (genvar g = 0; g < NUM_WARPS; g++) begin : g_used
        assign bus.warp_used[g*CW +: CW] = used_q[g];
    end
endmodule

// File: tb/tb_vx_ibuffer_sched.sv
// Bench: one round-robin and one greedy instance share stimulus; each has its own
// queue-based reference model of the buffer.
module tb_vx_ibuffer_sched;
    localparam int NW = 4;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enq_valid = 1'b0;
    logic [1:0]  enq_wid = '0;
    logic [63:0] enq_data = '0;
    logic        deq_ready = 1'b0;
    logic [3:0]  stall_mask = '0;
    logic        flush_valid = 1'b0;
    logic [1:0]  flush_wid = '0;

    always #5 clk = ~clk;

    vx_ibuffer_sched_if #(.NUM_WARPS(NW), .DEPTH(DEPTH), .DATAW(64)) bif0 ();
    vx_ibuffer_sched_if #(.NUM_WARPS(NW), .DEPTH(DEPTH), .DATAW(64)) bif1 ();

    assign bif0.enq_valid = enq_valid;   assign bif1.enq_valid = enq_valid;
    assign bif0.enq_wid = enq_wid;       assign bif1.enq_wid = enq_wid;
    assign bif0.enq_data = enq_data;     assign bif1.enq_data = enq_data;
    assign bif0.deq_ready = deq_ready;   assign bif1.deq_ready = deq_ready;
    assign bif0.stall_mask = stall_mask; assign bif1.stall_mask = stall_mask;
    assign bif0.flush_valid = flush_valid; assign bif1.flush_valid = flush_valid;
    assign bif0.flush_wid = flush_wid;   assign bif1.flush_wid = flush_wid;

    vx_ibuffer_sched #(.NUM_WARPS(NW), .DEPTH(DEPTH), .DATAW(64), .SCHED_MODE(0))
        dut_rr (.clk(clk), .reset(rst_n), .bus(bif0));
    vx_ibuffer_sched #(.NUM_WARPS(NW), .DEPTH(DEPTH), .DATAW(64), .SCHED_MODE(1))
        dut_gr (.clk(clk), .reset(rst_n), .bus(bif1));

    logic [1:0]        o_rdy, o_vld;
    logic [1:0][1:0]   o_wid;
    logic [1:0][63:0]  o_data;
    logic [1:0][7:0]   o_used;
    assign o_rdy  = {bif1.enq_ready, bif0.enq_ready};
    assign o_vld  = {bif1.deq_valid, bif0.deq_valid};
    assign o_wid  = {bif1.deq_wid,   bif0.deq_wid};
    assign o_data = {bif1.deq_data,  bif0.deq_data};
    assign o_used = {bif1.warp_used, bif0.warp_used};

    // Reference model: queue per (instance, warp), plus the output register.
    logic [63:0] mq [8][$];
    logic [63:0] dlog [2][$];
    bit          m_vld [2];
    int          m_wid [2];
    logic [63:0] m_data [2];
    int          m_last [2];
    bit          m_rdy [2];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mq[i].delete();
        for (int k = 0; k < 2; k++) begin
            m_vld[k] = 0; m_wid[k] = 0; m_data[k] = '0; m_last[k] = NW - 1;
            dlog[k].delete();
        end
    endtask

    task automatic model_step(input int k, input bit ev, input int ew, input logic [63:0] ed,
                              input bit dr, input logic [3:0] sm, input bit fv, input int fw);
        bit efire, rel;
        bit el [NW];
        int win, w;
        efire = ev && m_rdy[k];
        rel   = !m_vld[k] || dr || (fv && fw == m_wid[k]);
        win   = -1;
        for (int i = 0; i < NW; i++)
            el[i] = (mq[k*NW+i].size() > 0 || (efire && ew == i)) && !sm[i] && !(fv && fw == i);
        if (k == 1 && el[m_last[k]]) win = m_last[k];
        for (int i = 1; i <= NW; i++) begin
            w = (m_last[k] + i) % NW;
            if (win < 0 && el[w]) win = w;
        end
        if (efire) mq[k*NW+ew].push_back(ed);
        if (fv) mq[k*NW+fw].delete();
        if (rel) begin
            if (win >= 0) begin
                m_vld[k] = 1; m_wid[k] = win; m_last[k] = win;
                m_data[k] = mq[k*NW+win].pop_front();
            end else begin
                m_vld[k] = 0;
            end
        end
    endtask

    // Called at the negedge: drive, check enq_ready, clock, check registered outputs.
    task automatic cycle(input bit ev, input int ew, input logic [63:0] ed, input bit dr,
                         input logic [3:0] sm = 4'b0, input bit fv = 0, input int fw = 0);
        enq_valid = ev; enq_wid = 2'(ew); enq_data = ed; deq_ready = dr;
        stall_mask = sm; flush_valid = fv; flush_wid = 2'(fw);
        #1;
        for (int k = 0; k < 2; k++) begin
            m_rdy[k] = (mq[k*NW+ew].size() != DEPTH) && !(fv && fw == ew);
            chk($sformatf("enq_ready[%0d]", k), 64'(o_rdy[k]), 64'(m_rdy[k]));
            if (o_vld[k] && dr) dlog[k].push_back(o_data[k]);
            model_step(k, ev, ew, ed, dr, sm, fv, fw);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("deq_valid[%0d]", k), 64'(o_vld[k]), 64'(m_vld[k]));
            if (m_vld[k]) begin
                chk($sformatf("deq_wid[%0d]", k), 64'(o_wid[k]), 64'(m_wid[k]));
                chk($sformatf("deq_data[%0d]", k), o_data[k], m_data[k]);
            end
            for (int w = 0; w < NW; w++)
                chk($sformatf("used[%0d][%0d]", k, w), 64'(o_used[k][w*2 +: 2]),
                    64'(mq[k*NW+w].size()));
        end
        @(negedge clk);
    endtask

    // Asserts reset between edges and checks the immediate effect.
    task automatic do_reset();
        enq_valid = 0; deq_ready = 0; stall_mask = '0; flush_valid = 0;
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst deq_valid[%0d]", k), 64'(o_vld[k]), 64'd0);
            chk($sformatf("rst warp_used[%0d]", k), 64'(o_used[k]), 64'd0);
            chk($sformatf("rst deq_wid[%0d]", k), 64'(o_wid[k]), 64'd0);
            chk($sformatf("rst deq_data[%0d]", k), o_data[k], 64'd0);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_log(input int k, input string nm, input logic [63:0] e0,
                           input logic [63:0] e1, input logic [63:0] e2, input logic [63:0] e3);
        logic [63:0] exp [4];
        exp = '{e0, e1, e2, e3};
        chk({nm, " count"}, 64'(dlog[k].size()), 64'd4);
        if (dlog[k].size() == 4)
            for (int i = 0; i < 4; i++) chk($sformatf("%s #%0d", nm, i), dlog[k][i], exp[i]);
    endtask

    task automatic random_run(input int n);
        for (int i = 0; i < n; i++)
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 3), {$urandom, $urandom},
                  $urandom_range(0, 9) < 6,
                  ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 3));
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // Idle bypass: visible one cycle later, never occupies the FIFO.
        cycle(1, 2, 64'hA5, 1);
        chk("idle vld", 64'(o_vld[0]), 64'd1);
        chk("idle wid", 64'(o_wid[0]), 64'd2);
        chk("idle data", o_data[0], 64'hA5);
        chk("idle used2", 64'(o_used[0][5:4]), 64'd0);

        // Issue order RR vs greedy.
        do_reset();
        cycle(1, 0, 1, 0); cycle(1, 0, 2, 0); cycle(1, 1, 3, 0); cycle(1, 1, 4, 0);
        repeat (5) cycle(0, 0, 0, 1);
        chk_log(0, "rr order", 1, 3, 2, 4);
        chk_log(1, "greedy order", 1, 2, 3, 4);

        // Backpressure holds the output; full warp blocks only itself.
        do_reset();
        cycle(1, 0, 64'h77, 0);
        repeat (5) begin
            cycle(0, 0, 0, 0);
            chk("hold wid", 64'(o_wid[0]), 64'd0);
            chk("hold data", o_data[0], 64'h77);
        end
        cycle(1, 0, 64'h78, 0); cycle(1, 0, 64'h79, 0);
        enq_valid = 1; enq_wid = 2'd0; #1;
        chk("full w0 ready", 64'(o_rdy[0]), 64'd0);
        enq_wid = 2'd1; #1;
        chk("w1 ready", 64'(o_rdy[0]), 64'd1);
        cycle(0, 0, 0, 0);

        // Stall mask skips w0 without revoking the held one.
        do_reset();
        cycle(1, 0, 'h10, 0); cycle(1, 0, 'h11, 0); cycle(1, 1, 'h20, 0); cycle(1, 1, 'h21, 0);
        repeat (4) cycle(0, 0, 0, 1, 4'b0001);
        chk("stalled idle", 64'(o_vld[0]), 64'd0);
        repeat (2) cycle(0, 0, 0, 1);
        chk_log(0, "stall order", 'h10, 'h20, 'h21, 'h11);

        // Flush w1 while it is held and has two buffered entries.
        do_reset();
        cycle(1, 1, 'hA, 0); cycle(1, 1, 'hB, 0); cycle(1, 1, 'hC, 0); cycle(1, 0, 'hD, 0);
        enq_valid = 1; enq_wid = 2'd1; flush_valid = 1; flush_wid = 2'd1; #1;
        chk("flush enq_ready", 64'(o_rdy[0]), 64'd0);
        cycle(1, 1, 'hE, 0, 4'b0, 1, 1);
        chk("flush used1", 64'(o_used[0][3:2]), 64'd0);
        chk("flush vld", 64'(o_vld[0]), 64'd1);
        chk("flush wid", 64'(o_wid[0]), 64'd0);
        chk("flush data", o_data[0], 64'hD);

        // Random traffic, reset dropped mid-stream, then warp 0 wins first.
        random_run(1500);
        do_reset();
        cycle(1, 1, 'h51, 0, 4'hF); cycle(1, 0, 'h50, 0, 4'hF);
        cycle(0, 0, 0, 0);
        chk("post-reset rr wid", 64'(o_wid[0]), 64'd0);
        chk("post-reset gr wid", 64'(o_wid[1]), 64'd0);
        random_run(1500);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
